// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin/burst arbiter sharing one sync-read memory port between CPU and DMA
module mem_port_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int PRIORITY  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_lock,
  output logic       cpu_gnt,
  output logic       cpu_rvalid,
  output logic [7:0] cpu_rdata,
  input  logic       dma_req,
  input  logic       dma_we,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  output logic       dma_gnt,
  output logic       dma_rvalid,
  output logic [7:0] dma_rdata,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam int BW = ($clog2(MAX_BURST + 1) < 3) ? 3 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_OWN_CPU = 2'd1;
  localparam logic [1:0] S_OWN_DMA = 2'd2;
  localparam logic [1:0] S_LOCKED  = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt, burst_inc;
  logic          last_dma;
  logic          rd_pend, rd_owner;
  logic          both, pick_dma;

  assign both = cpu_req & dma_req;

  // pick_dma only matters when DMA is requesting; a lone CPU request always resolves to CPU.
  always_comb begin
    pick_dma = 1'b0;
    case (state)
      S_LOCKED:  pick_dma = 1'b0;
      S_IDLE:    pick_dma = both ? ~last_dma : dma_req;
      S_OWN_CPU: pick_dma = both ? (burst_cnt >= BURST_MAX) : dma_req;
      S_OWN_DMA: pick_dma = both ? (burst_cnt < BURST_MAX) : dma_req;
      default:   pick_dma = 1'b0;
    endcase
  end

  // Grants are gated by reset so every output is quiet while reset is held.
  assign cpu_gnt = reset & cpu_req & ~pick_dma;
  assign dma_gnt = reset & dma_req & pick_dma;

  assign mem_en    = cpu_gnt | dma_gnt;
  assign mem_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
  assign mem_addr  = ({8{cpu_gnt}} & cpu_addr) | ({8{dma_gnt}} & dma_addr);
  assign mem_wdata = ({8{cpu_gnt}} & cpu_wdata) | ({8{dma_gnt}} & dma_wdata);

  assign burst_inc = (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + 1'b1;

  always_comb begin
    state_nxt = (state == S_LOCKED) ? S_LOCKED : S_IDLE;
    burst_nxt = '0;
    if (cpu_gnt) begin
      state_nxt = cpu_lock ? S_LOCKED : S_OWN_CPU;
      burst_nxt = (state == S_OWN_CPU || state == S_LOCKED) ? burst_inc : BW'(1);
    end else if (dma_gnt) begin
      state_nxt = S_OWN_DMA;
      burst_nxt = (state == S_OWN_DMA) ? burst_inc : BW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      burst_cnt <= '0;
      last_dma  <= (PRIORITY == 0);
      rd_pend   <= 1'b0;
      rd_owner  <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      if (both && mem_en)
        last_dma <= dma_gnt;
      rd_pend   <= mem_en & ~mem_we;
      rd_owner  <= dma_gnt;
    end
  end

  assign cpu_rvalid = rd_pend & ~rd_owner;
  assign dma_rvalid = rd_pend & rd_owner;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : 8'h00;
  assign dma_rdata  = dma_rvalid ? mem_rdata : 8'h00;

endmodule
